// File: rtl/key_debounce_scan.sv
// key_debounce_scan: 4-key active-low debouncer with auto-repeat; key_in raw buttons -> key_flag one-cycle pulse, key_value one-hot key held until next flag
module key_debounce_scan #(
  parameter int DEBOUNCE_CYC = 2000000,
  parameter int REPEAT_DLY = 50000000,
  parameter int REPEAT_PER = 10000000,
  parameter int REPEAT_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_in,
  output logic       key_flag,
  output logic [3:0] key_value
);
  localparam int MAX_A = DEBOUNCE_CYC > REPEAT_DLY ? DEBOUNCE_CYC : REPEAT_DLY;
  localparam int MAX_P = MAX_A > REPEAT_PER ? MAX_A : REPEAT_PER;
  localparam int W = $clog2(MAX_P);
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} state_t;
  state_t state;
  logic [3:0] s1, s2, p, cand;
  logic [W-1:0] dcnt, rcnt, thr;
  logic rep, one_hot;
  function automatic logic [W-1:0] inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction
  assign p = ~s2;
  assign one_hot = (cand != 4'd0) && ((cand & (cand - 4'd1)) == 4'd0);
  assign thr = rep ? W'(REPEAT_PER - 1) : W'(REPEAT_DLY - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 4'hf;
      s2 <= 4'hf;
      state <= IDLE;
      cand <= 4'd0;
      dcnt <= '0;
      rcnt <= '0;
      rep <= 1'b0;
      key_flag <= 1'b0;
      key_value <= 4'd0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      key_flag <= 1'b0;
      case (state)
        IDLE: if (p != 4'd0) begin
          cand <= p;
          dcnt <= '0;
          state <= DEB_PRESS;
        end
        DEB_PRESS: if (p == 4'd0) state <= IDLE;
        else if (p != cand) begin
          cand <= p;
          dcnt <= '0;
        end else if (dcnt == W'(DEBOUNCE_CYC - 1)) begin
          state <= HELD;
          rcnt <= '0;
          rep <= 1'b0;
          if (one_hot) begin
            key_flag <= 1'b1;
            key_value <= cand;
          end
        end else dcnt <= inc(dcnt);
        HELD: if (p != cand) begin
          dcnt <= '0;
          state <= DEB_REL;
        end else if (REPEAT_EN != 0 && one_hot && rcnt == thr) begin
          key_flag <= 1'b1;
          rcnt <= '0;
          rep <= 1'b1;
        end else rcnt <= inc(rcnt);
        DEB_REL: if (p == cand) state <= HELD;
        else if (p != 4'd0) dcnt <= '0;
        else if (dcnt == W'(DEBOUNCE_CYC - 1)) state <= IDLE;
        else dcnt <= inc(dcnt);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_debounce_scan.sv
// tb_key_debounce_scan: checks two instances (auto-repeat off/on) against hand-derived flag edges via a scoreboard queue
module tb_key_debounce_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] key_in = 4'hf;
  logic flag0, flag1, pf0, pf1;
  logic [3:0] val0, val1;
  int e = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {int en; logic [3:0] val;} ev_t;
  typedef struct {logic [3:0] key; logic [3:0] val; logic hit;} vec_t;
  ev_t q0[$], q1[$];
  vec_t tbl[7];

  key_debounce_scan #(.DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_PER(8), .REPEAT_EN(0)) dut0 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_flag(flag0), .key_value(val0));
  key_debounce_scan #(.DEBOUNCE_CYC(4), .REPEAT_DLY(20), .REPEAT_PER(8), .REPEAT_EN(1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_flag(flag1), .key_value(val1));

  always #5 clk = ~clk;

  task automatic mon(input int k, input logic f, input logic [3:0] v, input logic pf);
    ev_t x;
    if (f) begin
      tests++;
      if (pf) begin
        fails++;
        $display("FAIL dut%0d consecutive_flag edge=%0d", k, e);
      end else if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        fails++;
        $display("FAIL dut%0d unexpected_flag edge=%0d value=%b", k, e, v);
      end else begin
        if (k == 0) x = q0.pop_front();
        else x = q1.pop_front();
        if (x.en != e || x.val != v) begin
          fails++;
          $display("FAIL dut%0d flag edge=%0d value=%b expected edge=%0d value=%b", k, e, v, x.en, x.val);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    e++;
    mon(0, flag0, val0, pf0);
    mon(1, flag1, val1, pf1);
    pf0 = flag0;
    pf1 = flag1;
  end

  task automatic expect_ev(input int en, input logic [3:0] v, input logic both);
    ev_t x;
    x.en = en;
    x.val = v;
    q1.push_back(x);
    if (both) q0.push_back(x);
  endtask

  task automatic drive(input logic [3:0] k, input int n, input logic r);
    repeat (n) begin
      @(negedge clk);
      key_in = k;
      rst = r;
      @(posedge clk);
    end
  endtask

  task automatic check_val(input string name, input logic [3:0] v);
    tests += 2;
    if (val0 !== v) begin
      fails++;
      $display("FAIL %s dut0 key_value=%b expected=%b", name, val0, v);
    end
    if (val1 !== v) begin
      fails++;
      $display("FAIL %s dut1 key_value=%b expected=%b", name, val1, v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    key_in = 4'hf;
    repeat (2) @(posedge clk);
    #2;
    tests += 2;
    if (flag0 !== 1'b0 || flag1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_flag got=%b%b expected=00", flag0, flag1);
    end
    check_val("reset_value", 4'd0);
    e = 0;
    q0.delete();
    q1.delete();
    pf0 = 1'b0;
    pf1 = 1'b0;
  endtask

  task automatic finish_scn(input string name, input logic [3:0] v);
    #2;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL %s missing_flags dut0=%0d dut1=%0d expected=0", name, q0.size(), q1.size());
    end
    check_val(name, v);
  endtask

  initial begin
    tbl[0] = '{4'b1110, 4'b0001, 1'b1};
    tbl[1] = '{4'b1101, 4'b0010, 1'b1};
    tbl[2] = '{4'b1011, 4'b0100, 1'b1};
    tbl[3] = '{4'b0111, 4'b1000, 1'b1};
    tbl[4] = '{4'b1100, 4'b0000, 1'b0};
    tbl[5] = '{4'b0101, 4'b0000, 1'b0};
    tbl[6] = '{4'b0000, 4'b0000, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_reset();
      if (tbl[i].hit) expect_ev(7, tbl[i].val, 1'b1);
      drive(tbl[i].key, 12, 1'b0);
      drive(4'hf, 8, 1'b0);
      finish_scn("table", tbl[i].val);
    end
    do_reset();
    expect_ev(7, 4'b0001, 1'b1);
    expect_ev(27, 4'b0001, 1'b0);
    expect_ev(35, 4'b0001, 1'b0);
    drive(4'b1110, 38, 1'b0);
    drive(4'hf, 10, 1'b0);
    finish_scn("clean_press", 4'b0001);
    do_reset();
    expect_ev(19, 4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1101, 2, 1'b0);
      drive(4'hf, 2, 1'b0);
    end
    drive(4'b1101, 15, 1'b0);
    drive(4'hf, 10, 1'b0);
    finish_scn("bounce", 4'b0010);
    do_reset();
    drive(4'b1100, 15, 1'b0);
    drive(4'hf, 10, 1'b0);
    #2;
    check_val("chord_hold", 4'd0);
    expect_ev(32, 4'b0100, 1'b1);
    drive(4'b1011, 10, 1'b0);
    drive(4'hf, 8, 1'b0);
    finish_scn("chord_then_key", 4'b0100);
    do_reset();
    expect_ev(7, 4'b0010, 1'b1);
    for (int i = 0; i < 5; i++) expect_ev(27 + 8 * i, 4'b0010, 1'b0);
    drive(4'b1101, 60, 1'b0);
    drive(4'hf, 10, 1'b0);
    finish_scn("auto_repeat", 4'b0010);
    do_reset();
    expect_ev(7, 4'b0010, 1'b1);
    expect_ev(30, 4'b0010, 1'b0);
    expect_ev(38, 4'b0010, 1'b0);
    expect_ev(46, 4'b0010, 1'b0);
    drive(4'b1101, 20, 1'b0);
    drive(4'hf, 2, 1'b0);
    drive(4'b1101, 28, 1'b0);
    drive(4'hf, 10, 1'b0);
    finish_scn("release_glitch", 4'b0010);
    do_reset();
    drive(4'b1110, 4, 1'b0);
    drive(4'b1110, 2, 1'b1);
    #2;
    check_val("mid_reset", 4'd0);
    expect_ev(13, 4'b0001, 1'b1);
    drive(4'b1110, 19, 1'b0);
    drive(4'hf, 10, 1'b0);
    finish_scn("reset_abort", 4'b0001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
